// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot line-select decoder with enable, valid flag and echoed select index.
// ACTIVE_LOW inverts every bit of y; REGISTERED=0 bypasses the output registers.
module decoder_3to8 #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REGISTERED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] y,
    output logic       valid,
    output logic [2:0] idx
);

    localparam logic [7:0] IDLE_Y = {8{ACTIVE_LOW}};

    logic [2:0] sel;
    logic [7:0] hot;
    logic [7:0] y_next;

    assign sel = {a, b, c};

    always_comb begin
        // NOTE: assigning the idle value first gives every path a value, so no latch is inferred.
        hot = 8'h00;
        if (en) begin
            case (sel)
                3'd0:    hot = 8'h01;
                3'd1:    hot = 8'h02;
                3'd2:    hot = 8'h04;
                3'd3:    hot = 8'h08;
                3'd4:    hot = 8'h10;
                3'd5:    hot = 8'h20;
                3'd6:    hot = 8'h40;
                3'd7:    hot = 8'h80;
                default: hot = 8'h00;
            endcase
        end
    end

    // XOR with the idle pattern applies the optional inversion uniformly.
    assign y_next = hot ^ IDLE_Y;

    generate
        if (REGISTERED) begin : g_reg
            logic [7:0] y_q;
            logic       valid_q;
            logic [2:0] idx_q;

            always_ff @(posedge clk) begin
                // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
                if (rst) begin
                    y_q     <= IDLE_Y;
                    valid_q <= 1'b0;
                    idx_q   <= 3'd0;
                end else begin
                    y_q     <= y_next;
                    valid_q <= en;
                    idx_q   <= sel;
                end
            end

            assign y     = y_q;
            assign valid = valid_q;
            assign idx   = idx_q;
        end else begin : g_comb
            // Keeps outputs qualified invalid until the first edge after reset release.
            logic rst_q;

            always_ff @(posedge clk) begin
                rst_q <= rst;
            end

            assign y     = y_next;
            assign valid = en & ~rst_q;
            assign idx   = sel;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench for decoder_3to8: default, active-low and combinational builds
// share one stimulus stream; expected values are hand-computed constants.
module tb_decoder_3to8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic c   = 1'b0;

    logic [7:0] y_reg, y_low, y_comb;
    logic       valid_reg, valid_low, valid_comb;
    logic [2:0] idx_reg, idx_low, idx_comb;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] EXP_HOT [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                           8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    decoder_3to8 #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .y(y_reg), .valid(valid_reg), .idx(idx_reg)
    );

    decoder_3to8 #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) dut_low (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .y(y_low), .valid(valid_low), .idx(idx_low)
    );

    decoder_3to8 #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .y(y_comb), .valid(valid_comb), .idx(idx_comb)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input logic [2:0] s);
        {a, b, c} = s;
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with sel=7, en=1.
        rst = 1'b1;
        en  = 1'b1;
        set_sel(3'd7);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_y",        y_reg,             8'h00);
            check("rst_valid",    {7'd0, valid_reg}, 8'h00);
            check("rst_idx",      {5'd0, idx_reg},   8'h00);
            check("rst_low_y",    y_low,             8'hFF);
            check("rst_low_valid",{7'd0, valid_low}, 8'h00);
            check("rst_comb_valid",{7'd0, valid_comb}, 8'h00);
        end
        rst = 1'b0;
        #1;
        check("rel_comb_valid", {7'd0, valid_comb}, 8'h00);
        check("rel_comb_y",     y_comb,             8'h80);
        check("rel_reg_hold",   y_reg,              8'h00);
        tick();
        check("rel_y",          y_reg,              8'h80);
        check("rel_valid",      {7'd0, valid_reg},  8'h01);
        check("rel_idx",        {5'd0, idx_reg},    8'h07);
        check("rel_low_y",      y_low,              8'h7F);
        check("rel_comb_valid2",{7'd0, valid_comb}, 8'h01);

        // Exhaustive sweep, one select per cycle.
        for (int i = 0; i < 8; i++) begin
            set_sel(3'(i));
            #1;
            check("sweep_comb_y",  y_comb, EXP_HOT[i]);
            check("sweep_lat_y",   y_reg,  (i == 0) ? 8'h80 : EXP_HOT[i-1]);
            tick();
            check("sweep_y",       y_reg,              EXP_HOT[i]);
            check("sweep_idx",     {5'd0, idx_reg},    8'(i));
            check("sweep_valid",   {7'd0, valid_reg},  8'h01);
            check("sweep_low_y",   y_low,              ~EXP_HOT[i]);
            check("sweep_comb_idx",{5'd0, idx_comb},   8'(i));
        end

        // Enable gating at sel=5.
        en = 1'b0;
        set_sel(3'd5);
        tick();
        check("en0_y",          y_reg,              8'h00);
        check("en0_valid",      {7'd0, valid_reg},  8'h00);
        check("en0_idx",        {5'd0, idx_reg},    8'h05);
        check("en0_low_y",      y_low,              8'hFF);
        check("en0_low_valid",  {7'd0, valid_low},  8'h00);
        check("en0_comb_y",     y_comb,             8'h00);
        check("en0_comb_valid", {7'd0, valid_comb}, 8'h00);
        en = 1'b1;
        tick();
        check("en1_y",          y_reg,              8'h20);
        check("en1_valid",      {7'd0, valid_reg},  8'h01);
        en = 1'b0;
        tick();
        check("en_drop_y",      y_reg,              8'h00);
        check("en_drop_valid",  {7'd0, valid_reg},  8'h00);

        // Reset mid-stream: sel 2, then rst during sel=3, then sel=4.
        en = 1'b1;
        set_sel(3'd2);
        tick();
        check("mid_y2",         y_reg,              8'h04);
        set_sel(3'd3);
        rst = 1'b1;
        tick();
        check("mid_rst_y",      y_reg,              8'h00);
        check("mid_rst_valid",  {7'd0, valid_reg},  8'h00);
        check("mid_rst_idx",    {5'd0, idx_reg},    8'h00);
        set_sel(3'd4);
        rst = 1'b0;
        tick();
        check("mid_y4",         y_reg,              8'h10);
        check("mid_valid4",     {7'd0, valid_reg},  8'h01);
        check("mid_idx4",       {5'd0, idx_reg},    8'h04);

        // Active-low select 6.
        set_sel(3'd6);
        tick();
        check("low_y6",         y_low,              8'hBF);
        check("low_valid6",     {7'd0, valid_low},  8'h01);

        // Combinational build: select change with no edge in between.
        set_sel(3'd1);
        #1;
        check("comb_y1",        y_comb,             8'h02);
        set_sel(3'd7);
        #2;
        check("comb_y7",        y_comb,             8'h80);
        check("comb_idx7",      {5'd0, idx_comb},   8'h07);
        check("comb_valid7",    {7'd0, valid_comb}, 8'h01);
        check("comb_reg_hold",  y_reg,              8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
